wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the Wishbone bus behind the AHB-to-Wishbone bridge between the bridge (master 0) and a second master (master 1, e.g. DMA or debug). It grants with round-robin priority and holds each grant for the whole `cyc` burst. Slave-side signals are muxed from the granted master. A watchdog terminates any strobe the slave leaves unanswered with an error to the master.

---
 rtl/wb_arbiter_2m.sv | 153 +++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone arbiter with cyc-locked
// grants, combinational slave mux and a per-strobe watchdog
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      r_st;
  logic        r_last;
  logic [15:0] r_cnt;

  logic        w_own0;
  logic        w_own1;
  logic        w_own_stb;
  logic        w_stall;
  logic        w_abort;
  logic [15:0] w_cnt_next;

  assign w_own0 = (r_st == ST_OWN0);
  assign w_own1 = (r_st == ST_OWN1);

  assign w_own_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);
  assign w_stall   = w_own_stb & ~s_ack_i & ~s_err_i;
  // A response landing in the terminal cycle beats the watchdog.
  assign w_abort   = w_stall & (r_cnt == TIMEOUT_CNT);

  assign w_cnt_next = (w_stall && !w_abort) ? r_cnt + 16'd1 : 16'd0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_st   <= ST_IDLE;
      r_last <= 1'b1;
      r_cnt  <= 16'd0;
    end else begin
      case (r_st)
        ST_IDLE: begin
          r_cnt <= 16'd0;
          if (m0_cyc_i && m1_cyc_i) begin
            r_st   <= r_last ? ST_OWN0 : ST_OWN1;
            r_last <= ~r_last;
          end else if (m0_cyc_i) begin
            r_st   <= ST_OWN0;
            r_last <= 1'b0;
          end else if (m1_cyc_i) begin
            r_st   <= ST_OWN1;
            r_last <= 1'b1;
          end
        end
        ST_OWN0: begin
          if (m0_cyc_i) begin
            r_cnt <= w_cnt_next;
          end else if (m1_cyc_i) begin
            r_st   <= ST_OWN1;
            r_last <= 1'b1;
            r_cnt  <= 16'd0;
          end else begin
            r_st  <= ST_IDLE;
            r_cnt <= 16'd0;
          end
        end
        ST_OWN1: begin
          if (m1_cyc_i) begin
            r_cnt <= w_cnt_next;
          end else if (m0_cyc_i) begin
            r_st   <= ST_OWN0;
            r_last <= 1'b0;
            r_cnt  <= 16'd0;
          end else begin
            r_st  <= ST_IDLE;
            r_cnt <= 16'd0;
          end
        end
        default: begin
          r_st  <= ST_IDLE;
          r_cnt <= 16'd0;
        end
      endcase
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    if (w_own0) begin
      s_cyc_o = m0_cyc_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (w_own1) begin
      s_cyc_o = m1_cyc_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  assign s_stb_o = w_own_stb & ~w_abort;

  assign m0_ack_o = w_own0 & s_ack_i & ~s_err_i;
  assign m1_ack_o = w_own1 & s_ack_i & ~s_err_i;
  assign m0_err_o = w_own0 & (s_err_i | w_abort);
  assign m1_err_o = w_own1 & (s_err_i | w_abort);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign gnt_o     = {w_own1, w_own0};
  assign timeout_o = w_abort;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed and random checks of wb_arbiter_2m against
// an owner/priority/stall-count reference model
module tb_wb_arbiter_2m;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  cyc, stb, we;
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [3:0]  sel [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, timeout_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  wb_arbiter_2m #(.TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wd[0]), .m0_sel_i(sel[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wd[1]), .m1_sel_i(sel[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad = 0;

  // Reference model: who owns the bus (-1 = nobody), who was granted last,
  // and how many cycles the owner's current strobe has gone unanswered.
  int   m_own = -1;
  int   m_prev = 1;
  int   m_stall = 0;
  logic e_abort;
  logic e_ack [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1;
    m_prev = 1;
    m_stall = 0;
  endtask

  task automatic check_model();
    int o;
    logic owned;
    o = m_own;
    owned = (o >= 0);
    e_abort = owned && stb[o] && !s_ack_i && !s_err_i && (m_stall == TO);
    for (int i = 0; i < 2; i++) e_ack[i] = (o == i) && s_ack_i && !s_err_i;
    chk("s_cyc", 32'(s_cyc_o), owned ? 32'(cyc[o]) : 32'd0);
    chk("s_stb", 32'(s_stb_o), (owned && stb[o] && !e_abort) ? 32'd1 : 32'd0);
    chk("s_we", 32'(s_we_o), owned ? 32'(we[o]) : 32'd0);
    chk("s_adr", s_adr_o, owned ? adr[o] : 32'd0);
    chk("s_dat", s_dat_o, owned ? wd[o] : 32'd0);
    chk("s_sel", 32'(s_sel_o), owned ? 32'(sel[o]) : 32'd0);
    chk("m0_ack", 32'(m0_ack_o), 32'(e_ack[0]));
    chk("m1_ack", 32'(m1_ack_o), 32'(e_ack[1]));
    chk("m0_err", 32'(m0_err_o), (o == 0 && (s_err_i || e_abort)) ? 32'd1 : 32'd0);
    chk("m1_err", 32'(m1_err_o), (o == 1 && (s_err_i || e_abort)) ? 32'd1 : 32'd0);
    chk("m0_dat", m0_dat_o, s_dat_i);
    chk("m1_dat", m1_dat_o, s_dat_i);
    chk("gnt", 32'(gnt_o), (o == 0) ? 32'd1 : (o == 1) ? 32'd2 : 32'd0);
    chk("timeout", 32'(timeout_o), 32'(e_abort));
  endtask

  task automatic settle();
    #3;
    check_model();
  endtask

  task automatic advance();
    int n;
    int ns;
    if (m_own < 0) begin
      if (cyc[0] && cyc[1]) n = 1 - m_prev;
      else if (cyc[0]) n = 0;
      else if (cyc[1]) n = 1;
      else n = -1;
    end else if (cyc[m_own]) n = m_own;
    else if (cyc[1 - m_own]) n = 1 - m_own;
    else n = -1;
    if (n != m_own || n < 0 || e_abort) ns = 0;
    else if (stb[n] && !s_ack_i && !s_err_i) ns = m_stall + 1;
    else ns = 0;
    @(posedge HCLK);
    #1;
    m_own = n;
    m_stall = ns;
    if (n >= 0) m_prev = n;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    #1;
    model_reset();
    check_model();
    @(posedge HCLK);
    #1;
    check_model();
    HRESET = 1'b0;
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] se);
    cyc[i] = c;
    stb[i] = s;
    we[i]  = w;
    adr[i] = a;
    wd[i]  = d;
    sel[i] = se;
  endtask

  task automatic idle_all();
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    s_ack_i = 0;
    s_err_i = 0;
  endtask

  logic [1:0] gq[$];
  logic [1:0] g_last;
  int idle_seen;
  int acks;

  initial begin
    idle_all();
    s_dat_i = 32'h1234_5678;
    @(posedge HCLK);
    #1;
    model_reset();
    check_model();
    HRESET = 1'b0;
    step();

    // Single master write, slave acks two cycles after grant
    set_m(0, 1, 1, 1, 32'h1000, 32'hDEAD_BEEF, 4'hF);
    settle();
    chk("gnt_before_grant", 32'(gnt_o), 32'd0);
    advance();
    settle();
    chk("gnt_m0", 32'(gnt_o), 32'd1);
    chk("adr_1000", s_adr_o, 32'h1000);
    advance();
    step();
    s_ack_i = 1;
    settle();
    chk("m0_ack_pulse", 32'(m0_ack_o), 32'd1);
    chk("m1_ack_quiet", 32'(m1_ack_o), 32'd0);
    advance();
    idle_all();
    step();
    step();

    // Async reset mid-strobe, then a tie grants m0
    set_m(0, 1, 1, 0, 32'h2000, 32'h0, 4'h3);
    step();
    step();
    do_reset();
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    set_m(1, 1, 1, 0, 32'h3000, 32'h0, 4'h1);
    step();
    settle();
    chk("tie_after_reset", 32'(gnt_o), 32'd1);
    advance();
    idle_all();
    step();
    step();

    // Round-robin with single beats and immediate re-request
    do_reset();
    set_m(0, 1, 1, 0, 32'h0A00, 32'h0, 4'hF);
    set_m(1, 1, 1, 1, 32'h0B00, 32'h55, 4'hF);
    s_ack_i = 1;
    g_last = 2'b00;
    idle_seen = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (gnt_o != 2'b00 && gnt_o != g_last) gq.push_back(gnt_o);
      if (g_last != 2'b00 && gnt_o == 2'b00) idle_seen++;
      if (gnt_o != 2'b00) g_last = gnt_o;
      advance();
      for (int i = 0; i < 2; i++) begin
        cyc[i] = !e_ack[i];
        stb[i] = !e_ack[i];
      end
    end
    chk("rr_count_ok", (gq.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    if (gq.size() >= 4) begin
      chk("rr_0", 32'(gq[0]), 32'd1);
      chk("rr_1", 32'(gq[1]), 32'd2);
      chk("rr_2", 32'(gq[2]), 32'd1);
      chk("rr_3", 32'(gq[3]), 32'd2);
    end
    chk("rr_no_idle", 32'(idle_seen), 32'd0);
    idle_all();
    step();
    step();

    // Burst lock: m1 holds cyc for 4 beats while m0 waits
    set_m(1, 1, 1, 1, 32'h4000, 32'hCAFE_0000, 4'hF);
    step();
    set_m(0, 1, 1, 0, 32'h5000, 32'h0, 4'hF);
    acks = 0;
    for (int k = 0; k < 12 && acks < 4; k++) begin
      s_ack_i = k[0];
      settle();
      chk("burst_gnt_m1", 32'(gnt_o), 32'd2);
      if (m1_ack_o) acks++;
      advance();
      wd[1] = wd[1] + 1;
    end
    chk("burst_beats", 32'(acks), 32'd4);
    cyc[1] = 0;
    stb[1] = 0;
    s_ack_i = 0;
    step();
    settle();
    chk("burst_handover", 32'(gnt_o), 32'd1);
    advance();
    idle_all();
    step();
    step();

    // Watchdog: silent slave, then same with an ack in the terminal cycle
    for (int v = 0; v < 2; v++) begin
      set_m(0, 1, 1, 0, 32'h6000, 32'h0, 4'hF);
      step();
      for (int k = 0; k <= TO; k++) begin
        s_ack_i = (v == 1 && k == TO);
        settle();
        chk("wd_timeout", 32'(timeout_o), (v == 0 && k == TO) ? 32'd1 : 32'd0);
        chk("wd_err", 32'(m0_err_o), (v == 0 && k == TO) ? 32'd1 : 32'd0);
        chk("wd_ack", 32'(m0_ack_o), (v == 1 && k == TO) ? 32'd1 : 32'd0);
        advance();
      end
      idle_all();
      step();
      step();
    end

    // Ack and err together: err wins
    set_m(1, 1, 1, 0, 32'h7000, 32'h0, 4'hF);
    step();
    s_ack_i = 1;
    s_err_i = 1;
    settle();
    chk("coll_err", 32'(m1_err_o), 32'd1);
    chk("coll_ack", 32'(m1_ack_o), 32'd0);
    advance();
    idle_all();
    step();

    // Random traffic against the model
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) cyc[i] = ~cyc[i];
        stb[i] = cyc[i] & ($urandom_range(0, 3) != 0);
        we[i]  = 1'($urandom);
        adr[i] = $urandom;
        wd[i]  = $urandom;
        sel[i] = 4'($urandom);
      end
      s_ack_i = ($urandom_range(0, 4) == 0);
      s_err_i = ($urandom_range(0, 11) == 0);
      s_dat_i = $urandom;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
